apu_wave_sequencer: RTL
=======================

# apu_wave_sequencer

Parametrised timer-plus-sequencer for the APU tone channels. It replaces the fixed 8-step square sequencer and merges the period divider and the waveform step counter into one block. It supports the pulse mode (4 selectable duty cycles, volume-scaled output) and the triangle mode (32-step ramp, gated advance). Two pulse instances and one triangle instance feed the APU mixer.

## Interface
Parameters:
- PERIOD_W, 11, width of the timer period reload value
- OUT_W, 4, width of the output level and of the volume input
- MIN_PERIOD, 8, pulse periods below this value mute the output

Ports:
- cpu_clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- apu_tick  in  1  single-cycle strobe, asserted every other cpu_clk cycle
- mode  in  1  0 = pulse, 1 = triangle
- duty  in  2  pulse duty select; ignored in triangle mode
- period  in  PERIOD_W  timer reload value
- volume  in  OUT_W  pulse amplitude
- restart  in  1  single-cycle strobe; resets the pulse step (register-$4003 write)
- gate  in  1  triangle advance enable (linear counter and length counter both non-zero)
- level  out  OUT_W  registered sample to the mixer
- step  out  5  current sequencer step; bits [4:3] are always 0 in pulse mode
- step_strobe  out  1  high for one cycle on every step advance

## Operation
- Timer enable `en`:
  - pulse mode: en = apu_tick
  - triangle mode: en = 1 every cycle
- On each `en` cycle:
  - If timer == 0: timer <= period, and the step advances.
  - Otherwise: timer <= timer - 1.
- Step advance:
  - pulse: step <= (step + 1) mod 8
  - triangle: step <= (step + 1) mod 32, only if gate = 1; when gate = 0 the timer still reloads but the step holds
- step_strobe is asserted on the same edge that the step changes. It is not asserted when the step is held by gate or overridden by restart.
- Pulse duty tables, listed as step 0..7:
  - duty 0 = 0100_0000
  - duty 1 = 0110_0000
  - duty 2 = 0111_1000
  - duty 3 = 1001_1111
- Pulse level: volume if table[duty][step] = 1 and period >= MIN_PERIOD, otherwise 0.
- Triangle level:
  - step < 16: level = 15 - step
  - step >= 16: level = step - 16
  - The triangle has no volume and no mute.
- restart (pulse mode only) sets step <= 0. The timer is not affected. restart takes priority over a coincident advance. In triangle mode restart is ignored.
- A change of mode, detected as a registered mode differing from the input, sets step <= 0 and timer <= period. This overrides any advance in that cycle.
- duty, volume and period may change at any time:
  - duty and volume take effect on level the next cycle.
  - period takes effect at the next reload.

## Timing
- Reset values: timer = 0, step = 0, step_strobe = 0, level = 0.
- level is registered from the current step, duty, volume and period, so it lags a step change by 1 cycle.
- With reset released and apu_tick toggling, the first pulse advance occurs on the first apu_tick, because the timer is 0 after reset.
- Step intervals:
  - pulse: 2*(period+1) cpu_clk cycles
  - triangle: period+1 cycles while gate is held
- period = 0 in triangle mode advances the step every cycle. This is legal and must not glitch.
- Wrap-around:
  - pulse step 7 -> 0
  - triangle step 31 -> 0, with level 15 at both step 0 and step 31
- reset asserted mid-operation overrides all inputs in that cycle. level = 0 on the following cycle.

## Test plan
- Reset: hold reset 3 cycles with arbitrary inputs -> level = 0, step = 0, step_strobe = 0 the cycle after release.
- Pulse duty: duty = 2, period = 3, volume = 9, apu_tick alternating:
  - step_strobe fires every 8 cycles
  - level sequence per step is 0, 9, 9, 9, 9, 0, 0, 0, repeating
- Triangle sweep: mode = 1, period = 0, gate = 1 -> step advances every cycle and level runs 15..0, 0..15, then wraps to 15.
- Triangle gate: gate = 0 for 10 cycles mid-ramp at step 20 -> step holds at 20, level holds at 4, no step_strobe; advance resumes when gate = 1.
- Restart and mute:
  - restart pulsed coincident with an advance -> step = 0, no step_strobe
  - period = 7, volume = 15 -> level stays 0 in all duty settings
  - period = 8 -> level is non-zero on high steps
- Mode switch and reset mid-operation:
  - toggling mode at step 5 -> step = 0 and timer = period the next cycle
  - reset asserted during a triangle ramp -> all outputs return to their reset values

Source files
------------

// File: rtl/apu_wave_sequencer.sv
// apu_wave_sequencer: combined period timer and waveform step sequencer for one APU tone
// channel. It handles pulse mode (8-step duty tables, volume-scaled, muted for short periods)
// and triangle mode (32-step ramp whose advance is gated).
//
// Ports:
//   cpu_clk     system clock, rising edge
//   reset       synchronous, active-high
//   apu_tick    one-cycle strobe every other cpu_clk; clocks the timer in pulse mode
//   mode        0 = pulse, 1 = triangle
//   duty        pulse duty-table select
//   period      timer reload value
//   volume      pulse amplitude
//   restart     pulse-only step reset strobe
//   gate        triangle advance enable
//   level       registered sample to the mixer
//   step        current sequencer step
//   step_strobe high for one cycle on every step advance
module apu_wave_sequencer #(
    parameter int unsigned PERIOD_W   = 11,
    parameter int unsigned OUT_W      = 4,
    parameter int unsigned MIN_PERIOD = 8
) (
    input  logic                cpu_clk,
    input  logic                reset,
    input  logic                apu_tick,
    input  logic                mode,
    input  logic [1:0]          duty,
    input  logic [PERIOD_W-1:0] period,
    input  logic [OUT_W-1:0]    volume,
    input  logic                restart,
    input  logic                gate,
    output logic [OUT_W-1:0]    level,
    output logic [4:0]          step,
    output logic                step_strobe
);

    localparam logic [PERIOD_W-1:0] MinPeriod = PERIOD_W'(MIN_PERIOD);

    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [4:0]          step_q, step_d;
    logic                strobe_q, strobe_d;
    logic [OUT_W-1:0]    level_q, level_d;
    logic                mode_q;
    logic                en;
    logic                advance;
    logic [7:0]          pattern;

    // Bit n of the pattern is the output state at pulse step n.
    function automatic logic [7:0] duty_pattern(input logic [1:0] d);
        case (d)
            2'd0:    return 8'b0000_0010;
            2'd1:    return 8'b0000_0110;
            2'd2:    return 8'b0001_1110;
            default: return 8'b1111_1001;
        endcase
    endfunction

    always_comb begin
        timer_d  = timer_q;
        step_d   = step_q;
        strobe_d = 1'b0;
        advance  = 1'b0;
        en       = mode ? 1'b1 : apu_tick;

        if (mode != mode_q) begin
            // Mode switch restarts the waveform from a clean reload.
            step_d  = 5'd0;
            timer_d = period;
        end else begin
            if (en) begin
                if (timer_q == '0) begin
                    timer_d = period;
                    advance = mode ? gate : 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            if (!mode && restart) begin
                step_d = 5'd0;
            end else if (advance) begin
                strobe_d = 1'b1;
                step_d   = mode ? step_q + 5'd1 : {2'b00, step_q[2:0] + 3'd1};
            end
        end
    end

    always_comb begin
        pattern = duty_pattern(duty);
        level_d = '0;
        if (mode) begin
            // 15..0 over steps 0..15, then 0..15 over steps 16..31.
            level_d = step_q[4] ? OUT_W'(step_q[3:0]) : OUT_W'(~step_q[3:0]);
        end else if (pattern[step_q[2:0]] && (period >= MinPeriod)) begin
            level_d = volume;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            timer_q  <= '0;
            step_q   <= 5'd0;
            strobe_q <= 1'b0;
            level_q  <= '0;
            // Track the mode during reset so release does not look like a mode switch.
            mode_q   <= mode;
        end else begin
            timer_q  <= timer_d;
            step_q   <= step_d;
            strobe_q <= strobe_d;
            level_q  <= level_d;
            mode_q   <= mode;
        end
    end

    assign level       = level_q;
    assign step        = step_q;
    assign step_strobe = strobe_q;

endmodule
